// File: rtl/alu_muldiv.sv
// Pipelined-datapath ALU: single-cycle arithmetic/logic/shift ops plus
// iterative unsigned multiply/divide into HI/LO, with a valid/ready handshake.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUctr,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t           state_r, state_nxt_s;
  logic [CNTW-1:0]  cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] work_hi_r, work_hi_nxt_s;
  logic [WIDTH-1:0] work_lo_r, work_lo_nxt_s;
  logic [WIDTH-1:0] opnd_r, opnd_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic             zero_r, zero_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic [WIDTH-1:0] hi_r, hi_nxt_s;
  logic [WIDTH-1:0] lo_r, lo_nxt_s;

  logic [SHW-1:0]     shamt_s;
  logic [WIDTH-1:0]   sum_s, diff_s, alu_res_s;
  logic               alu_ovf_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_nxt_s;
  logic [WIDTH:0]     div_sh_s, div_df_s;
  logic [WIDTH-1:0]   div_rem_nxt_s, div_quo_nxt_s;

  assign shamt_s = A[SHW-1:0];
  assign sum_s   = A + B;
  assign diff_s  = A - B;

  // Shift-add step: {work_hi, work_lo} holds partial product over the multiplier.
  assign mul_sum_s = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
  assign mul_nxt_s = {mul_sum_s, work_lo_r[WIDTH-1:1]};

  // Restoring step: work_hi is the partial remainder, work_lo shifts dividend out / quotient in.
  assign div_sh_s      = {work_hi_r, work_lo_r[WIDTH-1]};
  assign div_df_s      = div_sh_s - {1'b0, opnd_r};
  assign div_rem_nxt_s = div_df_s[WIDTH] ? div_sh_s[WIDTH-1:0] : div_df_s[WIDTH-1:0];
  assign div_quo_nxt_s = {work_lo_r[WIDTH-2:0], ~div_df_s[WIDTH]};

  // Single-cycle operation result and signed overflow.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (ALUctr)
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res_s = A & B;
      OP_OR:   alu_res_s = A | B;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_XOR:  alu_res_s = A ^ B;
      OP_NOR:  alu_res_s = ~(A | B);
      OP_SLL:  alu_res_s = B << shamt_s;
      OP_SRL:  alu_res_s = B >> shamt_s;
      OP_SRA:  alu_res_s = $signed(B) >>> shamt_s;
      OP_MFHI: alu_res_s = hi_r;
      OP_MFLO: alu_res_s = lo_r;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM next-state and next values for every register.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    work_hi_nxt_s   = work_hi_r;
    work_lo_nxt_s   = work_lo_r;
    opnd_nxt_s      = opnd_r;
    out_valid_nxt_s = 1'b0;
    result_nxt_s    = result_r;
    zero_nxt_s      = zero_r;
    ovf_nxt_s       = ovf_r;
    hi_nxt_s        = hi_r;
    lo_nxt_s        = lo_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          case (ALUctr)
            OP_MULTU: begin
              state_nxt_s   = MUL;
              cnt_nxt_s     = {CNTW{1'b0}};
              work_hi_nxt_s = {WIDTH{1'b0}};
              work_lo_nxt_s = B;
              opnd_nxt_s    = A;
            end
            OP_DIVU: begin
              if (B == {WIDTH{1'b0}}) begin
                out_valid_nxt_s = 1'b1;
                result_nxt_s    = {WIDTH{1'b1}};
                zero_nxt_s      = 1'b0;
                ovf_nxt_s       = 1'b0;
                lo_nxt_s        = {WIDTH{1'b1}};
                hi_nxt_s        = A;
              end else begin
                state_nxt_s   = DIV;
                cnt_nxt_s     = {CNTW{1'b0}};
                work_hi_nxt_s = {WIDTH{1'b0}};
                work_lo_nxt_s = A;
                opnd_nxt_s    = B;
              end
            end
            default: begin
              out_valid_nxt_s = 1'b1;
              result_nxt_s    = alu_res_s;
              zero_nxt_s      = (alu_res_s == {WIDTH{1'b0}});
              ovf_nxt_s       = alu_ovf_s;
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        work_hi_nxt_s = mul_nxt_s[2*WIDTH-1:WIDTH];
        work_lo_nxt_s = mul_nxt_s[WIDTH-1:0];
        if (cnt_r == LAST_CNT) begin
          state_nxt_s     = IDLE;
          cnt_nxt_s       = {CNTW{1'b0}};
          out_valid_nxt_s = 1'b1;
          hi_nxt_s        = mul_nxt_s[2*WIDTH-1:WIDTH];
          lo_nxt_s        = mul_nxt_s[WIDTH-1:0];
          result_nxt_s    = mul_nxt_s[WIDTH-1:0];
          zero_nxt_s      = (mul_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}});
          ovf_nxt_s       = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      DIV: begin
        work_hi_nxt_s = div_rem_nxt_s;
        work_lo_nxt_s = div_quo_nxt_s;
        if (cnt_r == LAST_CNT) begin
          state_nxt_s     = IDLE;
          cnt_nxt_s       = {CNTW{1'b0}};
          out_valid_nxt_s = 1'b1;
          hi_nxt_s        = div_rem_nxt_s;
          lo_nxt_s        = div_quo_nxt_s;
          result_nxt_s    = div_quo_nxt_s;
          zero_nxt_s      = (div_quo_nxt_s == {WIDTH{1'b0}});
          ovf_nxt_s       = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNTW{1'b0}};
      work_hi_r   <= {WIDTH{1'b0}};
      work_lo_r   <= {WIDTH{1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      ovf_r       <= 1'b0;
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      work_hi_r   <= work_hi_nxt_s;
      work_lo_r   <= work_lo_nxt_s;
      opnd_r      <= opnd_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      result_r    <= result_nxt_s;
      zero_r      <= zero_nxt_s;
      ovf_r       <= ovf_nxt_s;
      hi_r        <= hi_nxt_s;
      lo_r        <= lo_nxt_s;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign Result    = result_r;
  assign Zero      = zero_r;
  assign Overflow  = ovf_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed vectors push expectations,
// a negedge monitor pops and compares on every out_valid.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [3:0]  ALUctr;
  logic        out_valid;
  logic [31:0] Result;
  logic        Zero, Overflow;
  logic [31:0] hi, lo;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUctr(ALUctr), .out_valid(out_valid), .Result(Result),
    .Zero(Zero), .Overflow(Overflow), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [31:0] h;
    logic [31:0] l;
    int          lat;
    int          icyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ov_count = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every out_valid against the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      ov_count++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got Result %h expected no output", Result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, Result, e.res);
        chk({e.name, "_zero"}, {31'h0, Zero}, {31'h0, e.z});
        chk({e.name, "_ovf"}, {31'h0, Overflow}, {31'h0, e.ov});
        chk({e.name, "_hi"}, hi, e.h);
        chk({e.name, "_lo"}, lo, e.l);
        chk({e.name, "_latency"}, cyc - e.icyc, e.lat);
      end
    end
  end

  // Drive one request from a negedge; waits (bounded) for in_ready, returns at the next negedge.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic z,
                       input logic ov, input int lat, input bit push);
    exp_t e;
    int guard;
    ALUctr = op; A = a; B = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout: got in_ready %b expected 1", name, in_ready);
    end
    e.res = res; e.z = z; e.ov = ov; e.h = m_hi; e.l = m_lo;
    e.lat = lat; e.icyc = cyc; e.name = name;
    if (push) q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; A = 32'h0; B = 32'h0; ALUctr = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", Result, 32'h0);
    chk("rst_zero", {31'h0, Zero}, 32'h1);
    chk("rst_ovf", {31'h0, Overflow}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    // back-to-back single-cycle stream
    issue("add_ovf", 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1, 1'b1);
    issue("sub_zero", 4'b0001, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1, 1'b1);
    issue("slt", 4'b0100, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1, 1'b1);
    issue("sltu", 4'b0101, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1, 1'b1);
    issue("sub_ovf", 4'b0001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1, 1'b1);
    issue("and", 4'b0010, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1'b0, 1, 1'b1);
    issue("or", 4'b0011, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, 1'b0, 1, 1'b1);
    issue("xor", 4'b0110, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1'b0, 1'b0, 1, 1'b1);
    issue("nor", 4'b0111, 32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000, 1'b0, 1'b0, 1, 1'b1);
    issue("sll", 4'b1000, 32'h4, 32'h80000000, 32'h0, 1'b1, 1'b0, 1, 1'b1);
    issue("srl", 4'b1001, 32'h4, 32'h80000000, 32'h08000000, 1'b0, 1'b0, 1, 1'b1);
    issue("sra", 4'b1010, 32'h4, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1, 1'b1);
    issue("reserved", 4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0, 1, 1'b1);

    // multu with busy window measurement, then mfhi right after
    m_hi = 32'h1; m_lo = 32'hFFFFFFFE;
    issue("multu", 4'b1011, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 1'b1);
    n = 0;
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("multu_busy_cycles", n, 32);
    issue("mfhi", 4'b1101, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1, 1'b1);
    issue("mflo", 4'b1110, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 1, 1'b1);

    m_hi = 32'h2; m_lo = 32'd14;
    issue("divu", 4'b1100, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, 1'b1);
    m_hi = 32'h1234; m_lo = 32'hFFFFFFFF;
    issue("divu_by0", 4'b1100, 32'h1234, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 1'b1);
    issue("mflo_div0", 4'b1110, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 1'b1);

    // held request while busy, with inputs changing mid-op
    m_hi = 32'h0; m_lo = 32'd15;
    issue("multu_held", 4'b1011, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 33, 1'b1);
    ALUctr = 4'b0000; A = 32'd1000; B = 32'd1000; in_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy_in_ready", {31'h0, in_ready}, 32'h0);
    issue("held_sub", 4'b0001, 32'd50, 32'd8, 32'd42, 1'b0, 1'b0, 1, 1'b1);

    // reset in the middle of a multiply
    issue("multu_abort", 4'b1011, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
    chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_result", Result, 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    n = ov_count;
    repeat (40) @(negedge clk);
    chk("abort_no_out_valid", ov_count - n, 0);
    issue("post_rst_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
